// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and architectural register indices.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_RA   = 31;

    // True for registers with a fixed software role (hardwired zero, stack pointer, link).
    function automatic logic is_reserved(input logic [REG_ADDR_W-1:0] a);
        return (a == REG_ADDR_W'(REG_ZERO)) ||
               (a == REG_ADDR_W'(REG_SP))   ||
               (a == REG_ADDR_W'(REG_RA));
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: reset/zero forcing, same-cycle write bypass, array select.
module regfile_rdport
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned NREGS = 2 ** REG_ADDR_W,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                        reset,
    input  logic                        we,
    input  logic [AW-1:0]               wa,
    input  logic [WIDTH-1:0]            wd,
    input  logic [AW-1:0]               ra,
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    output logic [WIDTH-1:0]            rd
);

    // Priority: reset, $0, bypass of the in-flight write, stored value.
    always_comb begin
        rd = '0;
        if (reset) begin
            rd = '0;
        end else if (ra == AW'(REG_ZERO)) begin
            rd = '0;
        end else if (we && (wa == ra)) begin
            rd = wd;
        end else begin
            rd = regs[ra];
        end
    end

endmodule

// File: rtl/regfile.sv
// 32x32 MIPS register file: two combinational read ports, one clocked write port, $0 reads zero.
module regfile
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned NREGS = 2 ** REG_ADDR_W,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [NREGS-1:0][WIDTH-1:0] regs;

    // Reset wins over a same-cycle write; writes to $0 are dropped so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (we && (wa != AW'(REG_ZERO))) begin
            regs[wa] <= wd;
        end
    end

    regfile_rdport #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rdport1 (
        .reset (reset),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra    (ra1),
        .regs  (regs),
        .rd    (rd1)
    );

    regfile_rdport #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rdport2 (
        .reset (reset),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra    (ra2),
        .regs  (regs),
        .rd    (rd2)
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic against an array model.
module tb_regfile;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] model [32];
    bit          chk_en;

    regfile dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // What a read port must show this cycle, straight from the architectural rules.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (reset === 1'b1) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (we === 1'b1 && wa == a) return wd;
        return model[a];
    endfunction

    // Architectural state update at each rising edge.
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we === 1'b1 && wa != 5'd0) begin
            model[wa] = wd;
        end
    end

    // Every-cycle comparison of both ports against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rd1_model", rd1, exp_rd(ra1));
            check("rd2_model", rd2, exp_rd(ra2));
        end
    end

    task automatic drive(input logic r, input logic w, input logic [4:0] a_w, input logic [31:0] d,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        reset = r;
        we    = w;
        wa    = a_w;
        wd    = d;
        ra1   = a1;
        ra2   = a2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b1;
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        ra1   = '0;
        ra2   = '0;
        chk_en = 1'b1;
        settle();
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Reset clears a previously written register and the whole array.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        settle();
        check("bypass_r5", rd1, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        settle();
        check("stored_r5", rd1, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        settle();
        check("reset_forces_rd1", rd1, 32'h0);
        for (int a = 1; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a + 1));
            settle();
            check("cleared_rd1", rd1, 32'h0);
            check("cleared_rd2", rd2, 32'h0);
        end

        // Basic write/read and independent ports.
        drive(1'b0, 1'b1, 5'd8, 32'd100, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd9, 32'hFFFFFF9C, 5'd8, 5'd9);
        settle();
        check("r8_read", rd1, 32'd100);
        check("r9_bypass", rd2, 32'hFFFFFF9C);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
        settle();
        check("r8_stored", rd1, 32'd100);
        check("r9_stored", rd2, 32'hFFFFFF9C);

        // $0 immunity.
        drive(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        settle();
        check("r0_before", rd1, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        settle();
        check("r0_after", rd1, 32'h0);

        // Bypass on both ports over a stored value.
        drive(1'b0, 1'b1, 5'd3, 32'd7, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd3, 32'd42, 5'd3, 5'd3);
        settle();
        check("bypass_rd1", rd1, 32'd42);
        check("bypass_rd2", rd2, 32'd42);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        settle();
        check("r3_after_rd1", rd1, 32'd42);
        check("r3_after_rd2", rd2, 32'd42);

        // Reset beats a same-cycle write.
        drive(1'b1, 1'b1, 5'd4, 32'd55, 5'd4, 5'd3);
        settle();
        check("reset_write_rd1", rd1, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
        settle();
        check("r4_after_reset", rd1, 32'h0);
        check("r3_after_reset", rd2, 32'h0);

        // Write-enable low leaves the target untouched.
        drive(1'b0, 1'b1, 5'd8, 32'd100, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd9, 32'hFFFFFF9C, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd6, 32'hFFFFFFFF, 5'd6, 5'd8);
        settle();
        check("we_low_r6", rd1, 32'h0);
        check("we_low_r8", rd2, 32'd100);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd9);
        settle();
        check("r6_kept", rd1, 32'h0);
        check("r9_kept", rd2, 32'hFFFFFF9C);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
        settle();
        check("indep_rd1", rd1, 32'd100);
        check("indep_rd2", rd2, 32'hFFFFFF9C);

        // Unknown write enable must not disturb other registers.
        drive(1'b0, 1'bx, 5'd10, 32'hA5A5A5A5, 5'd8, 5'd9);
        drive(1'b0, 1'b1, 5'd10, 32'd5, 5'd8, 5'd9);
        settle();
        check("x_we_r8", rd1, 32'd100);
        check("x_we_r9", rd2, 32'hFFFFFF9C);

        // Architectural registers with software roles.
        drive(1'b0, 1'b1, 5'(REG_SP), 32'h7FFF_EFFC, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'(REG_RA), 32'h0040_0020, 5'(REG_SP), 5'(REG_RA));
        settle();
        check("sp_stored", rd1, 32'h7FFF_EFFC);
        check("ra_bypass", rd2, 32'h0040_0020);

        // Randomized traffic, addresses biased toward a small window to exercise bypass.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] rw;
            logic [4:0] r1;
            logic [4:0] r2;
            rw = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 4) == 0) ? r1 : 5'($urandom_range(0, 31));
            if (is_reserved(r2) && $urandom_range(0, 1) == 0) r2 = rw;
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), rw, $urandom(), r1, r2);
        end

        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        settle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
